// File: rtl/alu_vec.sv
// 16-lane signed Q8.8 SIMD ALU with a broadcastable scalar B operand and per-lane {N,Z,C,V} flags.
// One cycle latency, captures every edge; no handshake, so it never stalls.
module alu_vec #(
    parameter int LANES = 16,
    parameter int LW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*LW-1:0] a,
    input  logic [LANES*LW-1:0] b,
    input  logic [2:0]          opcode,
    input  logic                flag_scalar,
    output logic [LANES*LW-1:0] result,
    output logic [LANES*4-1:0]  flags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    localparam int PQW = 2*LW - LW/2;

    op_e                 w_op;
    logic                w_sub;
    logic [LANES*LW-1:0] w_result;
    logic [LANES*4-1:0]  w_flags;
    logic [LANES*LW-1:0] r_result;
    logic [LANES*4-1:0]  r_flags;

    assign w_op  = op_e'(opcode);
    assign w_sub = (w_op == OP_SUB);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LW-1:0]          w_a;
            logic [LW-1:0]          w_b;
            logic [LW-1:0]          w_addb;
            logic [LW:0]            w_sum;
            logic signed [2*LW-1:0] w_prod;
            logic [PQW-1:0]         w_pq;
            logic                   w_mul_ovf;
            logic [3:0]             w_sh;
            logic [LW:0]            w_sll;
            logic [LW:0]            w_sra;
            logic [LW-1:0]          w_res;
            logic                   w_c;
            logic                   w_v;

            assign w_a    = a[gi*LW +: LW];
            assign w_b    = flag_scalar ? b[LW-1:0] : b[gi*LW +: LW];
            assign w_addb = w_sub ? ~w_b : w_b;
            assign w_sum  = {1'b0, w_a} + {1'b0, w_addb} + {{LW{1'b0}}, w_sub};

            // Arithmetic shift of the full product drops 8 fraction bits (floor);
            // the top LW/2+1 bits of the shifted value must be a pure sign extension.
            assign w_prod    = $signed(w_a) * $signed(w_b);
            assign w_pq      = PQW'(w_prod >>> (LW/2));
            assign w_mul_ovf = ~((&w_pq[PQW-1:LW-1]) | ~(|w_pq[PQW-1:LW-1]));

            // Extra guard bit catches the last bit shifted out as the carry.
            assign w_sh  = w_b[3:0];
            assign w_sll = {1'b0, w_a} << w_sh;
            assign w_sra = $signed({w_a, 1'b0}) >>> w_sh;

            always_comb begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
                case (w_op)
                    OP_ADD, OP_SUB: begin
                        w_res = w_sum[LW-1:0];
                        w_c   = w_sum[LW];
                        w_v   = (w_a[LW-1] == w_addb[LW-1]) && (w_sum[LW-1] != w_a[LW-1]);
                    end
                    OP_MUL: begin
                        w_res = w_pq[LW-1:0];
                        w_v   = w_mul_ovf;
                    end
                    OP_AND: w_res = w_a & w_b;
                    OP_OR:  w_res = w_a | w_b;
                    OP_XOR: w_res = w_a ^ w_b;
                    OP_SLL: begin
                        w_res = w_sll[LW-1:0];
                        w_c   = w_sll[LW];
                    end
                    OP_SRA: begin
                        w_res = w_sra[LW:1];
                        w_c   = w_sra[0];
                    end
                    default: begin
                        w_res = '0;
                    end
                endcase
            end

            assign w_result[gi*LW +: LW] = w_res;
            assign w_flags[gi*4 +: 4]    = {w_res[LW-1], ~(|w_res), w_c, w_v};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_alu_vec.sv
// Directed-vector bench for alu_vec; expected responses queue up at issue time and a monitor checks them.
module tb_alu_vec;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] a;
    logic [255:0] b;
    logic [2:0]   opcode;
    logic         flag_scalar;
    logic [255:0] result;
    logic [63:0]  flags;

    always #5 clk = ~clk;

    alu_vec dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .flag_scalar (flag_scalar),
        .result      (result),
        .flags       (flags)
    );

    typedef struct {
        logic [255:0] r;
        logic [63:0]  f;
        string        nm;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic         in_vld = 1'b0;
    logic [255:0] va, vb, vr;
    logic [63:0]  vf;
    logic [2:0]   vop;
    logic         vsc;

    task automatic cmp_r(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s result got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp_f(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s flags got %h want %h", nm, act, exp);
        end
    endtask

    // Unused lanes carry zero operands, so their expected flags are one per-vector default.
    task automatic start(input logic [2:0] op, input logic sc, input logic [3:0] df);
        va  = '0;
        vb  = '0;
        vr  = '0;
        vf  = {16{df}};
        vop = op;
        vsc = sc;
    endtask

    task automatic lane(input int i, input logic [15:0] la, input logic [15:0] lb,
                        input logic [15:0] lr, input logic [3:0] lf);
        va[16*i +: 16] = la;
        vb[16*i +: 16] = lb;
        vr[16*i +: 16] = lr;
        vf[4*i +: 4]   = lf;
    endtask

    task automatic drive(input string nm);
        exp_t e;
        a           = va;
        b           = vb;
        opcode      = vop;
        flag_scalar = vsc;
        in_vld      = 1'b1;
        e.r  = vr;
        e.f  = vf;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input string nm);
        @(negedge clk);
        drive(nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (in_vld && !rst) begin
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty result got %h want queued entry", result);
                end else begin
                    e = sb.pop_front();
                    cmp_r(e.nm, result, e.r);
                    cmp_f(e.nm, flags, e.f);
                end
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending got %0d want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; opcode = '0; flag_scalar = 1'b0;
        #1;
        cmp_r("rst_init", result, '0);
        cmp_f("rst_init", flags, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        start(3'b010, 1'b0, 4'b0100);
        lane(15, 16'h0180, 16'hFE40, 16'hFD60, 4'b1000);
        lane(14, 16'h0140, 16'h0180, 16'h01E0, 4'b0000);
        lane(13, 16'h0380, 16'h0200, 16'h0700, 4'b0000);
        lane(12, 16'h0180, 16'h0340, 16'h04E0, 4'b0000);
        lane(11, 16'h0080, 16'h05C0, 16'h02E0, 4'b0000);
        lane(10, 16'h0300, 16'hFF80, 16'hFE80, 4'b1000);
        lane(9,  16'h0140, 16'hFE80, 16'hFE20, 4'b1000);
        issue("mul_vec");

        // Per-lane b values stay loaded to show they are ignored in scalar mode.
        start(3'b010, 1'b1, 4'b0100);
        lane(15, 16'h0180, 16'hFE40, 16'h7E4B, 4'b0000);
        lane(14, 16'h0140, 16'h0180, 16'h693E, 4'b0000);
        lane(13, 16'h0380, 16'h0200, 16'h26AF, 4'b0001);
        lane(12, 16'h0180, 16'h0340, 16'h7E4B, 4'b0000);
        lane(11, 16'h0080, 16'h05C0, 16'h2A19, 4'b0000);
        lane(10, 16'h0300, 16'hFF80, 16'hFC96, 4'b1001);
        lane(9,  16'h0140, 16'hFE80, 16'h693E, 4'b0000);
        lane(0,  16'h0000, 16'h5432, 16'h0000, 4'b0100);
        issue("mul_scalar");

        start(3'b000, 1'b0, 4'b0100);
        lane(0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
        lane(1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
        lane(2, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
        issue("add_bnd");

        start(3'b001, 1'b0, 4'b0110);
        lane(0, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000);
        lane(1, 16'h0005, 16'h0003, 16'h0002, 4'b0010);
        lane(2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
        issue("sub_bnd");

        start(3'b000, 1'b0, 4'b0100);
        lane(0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
        lane(1, 16'h0001, 16'h0002, 16'h0003, 4'b0000);
        issue("lane_iso");

        start(3'b101, 1'b0, 4'b0100);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] v;
            v = 16'(i * 16'h1111 + 16'h00A5);
            lane(i, v, v, 16'h0000, 4'b0100);
        end
        issue("xor_eq");

        start(3'b011, 1'b0, 4'b0100);
        lane(0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000);
        lane(1, 16'h00FF, 16'hFF00, 16'h0000, 4'b0100);
        issue("and");

        start(3'b100, 1'b0, 4'b0100);
        lane(0, 16'h0F0F, 16'hF000, 16'hFF0F, 4'b1000);
        issue("or");

        start(3'b111, 1'b0, 4'b0100);
        lane(0, 16'h8000, 16'h0004, 16'hF800, 4'b1000);
        lane(1, 16'h8001, 16'h0001, 16'hC000, 4'b1010);
        lane(2, 16'h7F00, 16'h0008, 16'h007F, 4'b0000);
        issue("sra");

        start(3'b110, 1'b0, 4'b0100);
        lane(0, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
        lane(1, 16'h00FF, 16'h0008, 16'hFF00, 4'b1000);
        lane(2, 16'h4000, 16'h0002, 16'h0000, 4'b0110);
        issue("sll");

        start(3'b110, 1'b1, 4'b0100);
        lane(0, 16'h8001, 16'h0000, 16'h8001, 4'b1000);
        lane(1, 16'h00FF, 16'h0007, 16'h00FF, 4'b0000);
        issue("sll0_scalar");

        @(negedge clk);
        in_vld = 1'b0;
        drain();

        #2;
        rst = 1'b1;
        #1;
        cmp_r("rst_async", result, '0);
        cmp_f("rst_async", flags, '0);
        @(posedge clk);
        #1;
        cmp_r("rst_hold", result, '0);
        cmp_f("rst_hold", flags, '0);

        start(3'b100, 1'b0, 4'b0100);
        lane(3, 16'h1234, 16'h4321, 16'h5335, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        drive("post_rst");
        @(negedge clk);
        in_vld = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
